// File: rtl/conv_sram_icb_slv_if.sv
// ICB command/response bundle between the conv engine initiator and the SRAM responder.
interface conv_sram_icb_slv_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/conv_sram_icb_slv.sv
// ICB responder backed by a single-port 32-bit SRAM with byte enables.
// Commands enter a one-cycle read stage, then an in-order response FIFO with a bypass path.
module conv_sram_icb_slv #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned AW        = 10,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  conv_sram_icb_slv_if.slave bus
);

  localparam int unsigned   PW      = $clog2(RSP_DEPTH);
  localparam int unsigned   CW      = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic [31:0]   r_mem [0:(1<<AW)-1];
  logic [31:0]   r_rd_q;
  logic [CW-1:0] r_cnt;
  logic          r_s1_vld;
  logic          r_s1_err;
  logic          r_s1_rd;
  logic [32:0]   r_fifo [0:RSP_DEPTH-1];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;

  logic [31:0]   w_off;
  logic          w_unused_off;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic          w_ready;
  logic          w_fire;
  logic [CW-1:0] w_fifo_n;
  logic          w_fifo_empty;
  logic [31:0]   w_s1_data;
  logic [32:0]   w_head;
  logic          w_rsp_valid;
  logic          w_pop;
  logic          w_push;

  assign w_off        = bus.icb_cmd_addr - BASE_ADDR;
  assign w_unused_off = ^w_off[1:0];
  assign w_err        = (|w_off[31:AW+2]) | (|bus.icb_cmd_addr[1:0]);
  assign w_idx        = w_off[AW+1:2];

  assign w_ready = !rst && (r_cnt < DEPTH_C);
  assign w_fire  = bus.icb_cmd_valid & w_ready;

  // Outstanding count covers the read stage, so the FIFO holds the remainder.
  assign w_fifo_n     = r_cnt - CW'(r_s1_vld);
  assign w_fifo_empty = (w_fifo_n == '0);
  assign w_s1_data    = r_s1_rd ? r_rd_q : 32'h0;
  assign w_head       = w_fifo_empty ? {r_s1_err, w_s1_data} : r_fifo[r_rp];
  assign w_rsp_valid  = !w_fifo_empty || r_s1_vld;
  assign w_pop        = w_rsp_valid & bus.icb_rsp_ready;
  // The stage bypasses the FIFO only when it is both the head and consumed this cycle.
  assign w_push       = r_s1_vld & ~(w_pop & w_fifo_empty);

  assign bus.icb_cmd_ready = w_ready;
  assign bus.icb_rsp_valid = w_rsp_valid;
  assign bus.icb_rsp_rdata = w_rsp_valid ? w_head[31:0] : 32'h0;
  assign bus.icb_rsp_err   = w_rsp_valid & w_head[32];

  always_ff @(posedge clk) begin
    if (w_fire && !w_err) begin
      if (bus.icb_cmd_read) begin
        r_rd_q <= r_mem[w_idx];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (bus.icb_cmd_wmask[i]) begin
            r_mem[w_idx][8*i +: 8] <= bus.icb_cmd_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wp] <= {r_s1_err, w_s1_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_s1_vld <= 1'b0;
      r_s1_err <= 1'b0;
      r_s1_rd  <= 1'b0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else begin
      r_s1_vld <= w_fire;
      r_s1_err <= w_fire & w_err;
      r_s1_rd  <= w_fire & bus.icb_cmd_read & ~w_err;
      if (w_fire && !w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (!w_fire && w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_push) begin
        r_wp <= r_wp + PW'(1);
      end
      if (w_pop && !w_fifo_empty) begin
        r_rp <= r_rp + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_sram_icb_slv.sv
// Randomised bench for conv_sram_icb_slv against a queue-based transaction model.
module tb_conv_sram_icb_slv;

  localparam logic [31:0] BASE      = 32'h2000_0000;
  localparam int unsigned AW        = 10;
  localparam int unsigned RSP_DEPTH = 2;
  localparam logic [31:0] WIN       = 32'd4 << AW;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst;
  conv_sram_icb_slv_if bus ();

  conv_sram_icb_slv #(
    .BASE_ADDR (BASE),
    .AW        (AW),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  logic        chk_en;
  logic        m_fire;
  logic        m_pop;
  logic [31:0] m_mem [0:(1<<AW)-1];
  rsp_t        exp_q [$];
  rsp_t        obs_log [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level model: every accepted command yields exactly one response, in order.
  task automatic model_cmd(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wm);
    logic [31:0] off;
    logic [31:0] w;
    rsp_t        r;
    off = a - BASE;
    if (off >= WIN || a[1:0] != 2'b00) begin
      r = '{data: 32'h0, err: 1'b1};
    end else if (rd) begin
      r = '{data: m_mem[off >> 2], err: 1'b0};
    end else begin
      w = m_mem[off >> 2];
      for (int i = 0; i < 4; i++) if (wm[i]) w[8*i +: 8] = wd[8*i +: 8];
      m_mem[off >> 2] = w;
      r = '{data: 32'h0, err: 1'b0};
    end
    exp_q.push_back(r);
  endtask

  task automatic step(input logic r, input logic v, input logic rd, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] wm, input logic rr);
    logic exp_ready;
    logic exp_valid;
    rsp_t obs;
    @(negedge clk);
    rst               = r;
    bus.icb_cmd_valid = v;
    bus.icb_cmd_read  = rd;
    bus.icb_cmd_addr  = a;
    bus.icb_cmd_wdata = wd;
    bus.icb_cmd_wmask = wm;
    bus.icb_rsp_ready = rr;
    #1;
    exp_ready = !r && (exp_q.size() < RSP_DEPTH);
    exp_valid = exp_q.size() != 0;
    if (chk_en) begin
      check_val("cmd_ready", 32'(bus.icb_cmd_ready), 32'(exp_ready));
      check_val("rsp_valid", 32'(bus.icb_rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        check_val("rsp_rdata", bus.icb_rsp_rdata, exp_q[0].data);
        check_val("rsp_err", 32'(bus.icb_rsp_err), 32'(exp_q[0].err));
      end
    end
    m_fire = v && exp_ready;
    m_pop  = exp_valid && rr;
    obs    = '{data: bus.icb_rsp_rdata, err: bus.icb_rsp_err};
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (m_pop) begin
        void'(exp_q.pop_front());
        obs_log.push_back(obs);
      end
      if (m_fire) model_cmd(rd, a, wd, wm);
    end
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rr);
  endtask

  task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] wm, input logic rr);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, rd, a, wd, wm, rr);
      if (m_fire) break;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    bus.icb_cmd_valid = 1'b0;
    bus.icb_cmd_read  = 1'b0;
    bus.icb_cmd_addr  = 32'h0;
    bus.icb_cmd_wdata = 32'h0;
    bus.icb_cmd_wmask = 4'h0;
    bus.icb_rsp_ready = 1'b0;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, BASE, 32'h0, 4'h0, 1'b0);
    chk_en = 1'b1;

    // Reset, idle, then reset with two responses pending.
    idle(1'b0);
    send(1'b1, BASE, 32'h0, 4'h0, 1'b0);
    send(1'b1, BASE + 32'h4, 32'h0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
    idle(1'b0);
    check_val("rst_drop_valid", 32'(bus.icb_rsp_valid), 32'h0);
    check_val("rst_drop_rdata", bus.icb_rsp_rdata, 32'h0);
    check_val("rst_drop_err", 32'(bus.icb_rsp_err), 32'h0);

    // Byte-masked write merge.
    obs_log.delete();
    send(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    send(1'b0, BASE + 32'h10, 32'h0000_00AA, 4'b0001, 1'b1);
    send(1'b1, BASE + 32'h10, 32'h0, 4'h0, 1'b1);
    drain();
    check_val("merge_cnt", 32'(obs_log.size()), 32'd3);
    if (obs_log.size() == 3) begin
      check_val("merge_w0", obs_log[0].data, 32'h0);
      check_val("merge_w1_err", 32'(obs_log[1].err), 32'h0);
      check_val("merge_rd", obs_log[2].data, 32'hDEAD_BEAA);
      check_val("merge_rd_err", 32'(obs_log[2].err), 32'h0);
    end

    // Back-to-back streaming reads.
    for (int i = 0; i < 16; i++) send(1'b0, BASE + 32'(4 * i), 32'(i), 4'hF, 1'b1);
    drain();
    obs_log.delete();
    for (int i = 0; i < 16; i++) send(1'b1, BASE + 32'(4 * i), 32'h0, 4'h0, 1'b1);
    drain();
    check_val("stream_cnt", 32'(obs_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < obs_log.size(); i++) begin
      check_val("stream_rd", obs_log[i].data, 32'(i));
    end

    // Backpressure: two accepted, third stalls until after the first pop.
    obs_log.delete();
    send(1'b1, BASE, 32'h0, 4'h0, 1'b0);
    send(1'b1, BASE + 32'h4, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, BASE + 32'h8, 32'h0, 4'h0, 1'b0);
    check_val("bp_stall_ready", 32'(bus.icb_cmd_ready), 32'h0);
    check_val("bp_hold_rdata", bus.icb_rsp_rdata, 32'h0);
    step(1'b0, 1'b1, 1'b1, BASE + 32'h8, 32'h0, 4'h0, 1'b1);
    step(1'b0, 1'b1, 1'b1, BASE + 32'h8, 32'h0, 4'h0, 1'b1);
    check_val("bp_accept_after_pop", 32'(bus.icb_cmd_ready), 32'h1);
    drain();
    check_val("bp_cnt", 32'(obs_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < obs_log.size(); i++) begin
      check_val("bp_order", obs_log[i].data, 32'(i));
    end

    // Error decode and no side effects on the boundary words.
    send(1'b0, BASE, 32'h1111_1111, 4'hF, 1'b1);
    send(1'b0, BASE + WIN - 32'h4, 32'h2222_2222, 4'hF, 1'b1);
    drain();
    obs_log.delete();
    send(1'b1, BASE + WIN, 32'h0, 4'h0, 1'b1);
    send(1'b0, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1);
    send(1'b1, BASE + 32'h2, 32'h0, 4'h0, 1'b1);
    send(1'b0, BASE + 32'h1, 32'hFFFF_FFFF, 4'hF, 1'b1);
    send(1'b0, BASE + WIN, 32'hFFFF_FFFF, 4'hF, 1'b1);
    send(1'b1, BASE, 32'h0, 4'h0, 1'b1);
    send(1'b1, BASE + WIN - 32'h4, 32'h0, 4'h0, 1'b1);
    drain();
    check_val("err_cnt", 32'(obs_log.size()), 32'd7);
    for (int i = 0; i < 5 && i < obs_log.size(); i++) begin
      check_val("err_flag", 32'(obs_log[i].err), 32'h1);
      check_val("err_rdata", obs_log[i].data, 32'h0);
    end
    if (obs_log.size() == 7) begin
      check_val("err_word0", obs_log[5].data, 32'h1111_1111);
      check_val("err_wordlast", obs_log[6].data, 32'h2222_2222);
    end

    // Random traffic with mixed backpressure.
    for (int i = 0; i < 32; i++) send(1'b0, BASE + 32'(4 * i), $urandom, 4'hF, 1'b1);
    drain();
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a;
      a = BASE + 32'(4 * $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a = BASE + WIN + 32'(4 * $urandom_range(0, 7));
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 4) == 0) idle(1'($urandom_range(0, 1)));
    end
    drain();
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
